// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and the
// parity helper also used by the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Narrow words are passed zero-extended; the extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [15:0] word, input int unsigned mode);
    if (mode == PAR_ODD)  return ~^word;
    if (mode == PAR_EVEN) return ^word;
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Producer-side valid/ready word handshake into the UART transmitter.
interface uart_tx_param_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO in front of the UART shifter.
module uart_tx_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
  end

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (word width, baud divider, parity, stop bits).
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO ahead of the shifter.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_MODE  = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  uart_tx_param_if.slave                    s,
  output logic                              tx,
  output logic                              busy,
  output logic                              tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_W);

  if (PARITY_MODE > PAR_ODD || STOP_BITS < 1 || STOP_BITS > 2 ||
      DATA_W < 5 || DATA_W > 16 || CLKS_PER_BIT < 2) begin : g_bad_param
    $error("uart_tx_param: unsupported parameter combination");
  end

  tx_state_t         state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic [DATA_W-1:0] sh_q, sh_n, word_in;
  logic              par_q, par_n;
  logic              avail, load, bit_end;

`ifdef UART_TX_FIFO_EN
  logic              full, empty;
  logic [DATA_W-1:0] fifo_rd;

  assign s.s_ready = !full && !rst;
  assign avail     = !empty;
  assign word_in   = fifo_rd;

  uart_tx_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s.s_valid && s.s_ready),
    .wdata (s.s_data),
    .pop   (load),
    .rdata (fifo_rd),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
`else
  assign s.s_ready  = (state_q == IDLE) && !rst;
  assign avail      = s.s_valid && s.s_ready;
  assign word_in    = s.s_data;
  assign fifo_count = '0;
`endif

  assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      sh_q    <= sh_n;
      par_q   <= par_n;
    end
  end

  // idx_q counts data bits in DATA and stop bits in STOP.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    sh_n    = sh_q;
    par_n   = par_q;
    load    = 1'b0;
    tx_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (avail) load = 1'b1;
      end
      START: begin
        cnt_n = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        cnt_n = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_n = '0;
          sh_n  = sh_q >> 1;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            idx_n   = '0;
            state_n = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        cnt_n = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = STOP;
        end
      end
      STOP: begin
        cnt_n = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_n = '0;
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            tx_done = !rst;
            idx_n   = '0;
            if (avail) load = 1'b1;
            else       state_n = IDLE;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      state_n = START;
      cnt_n   = '0;
      idx_n   = '0;
      sh_n    = word_in;
      par_n   = parity_bit(16'(word_in), PARITY_MODE);
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = sh_q[0];
      PARITY:  tx = par_q;
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench: three transmitter configurations checked every cycle
// against a frame-level model (expected line/busy/done queue per instance).
module tb_uart_tx_param;
  localparam int unsigned CPB = 4;

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exp_t        exp_q [3][$];
  logic [15:0] mfifo [3][$];
  int n_checks = 0;
  int n_fail   = 0;
  int run[3]       = '{default: 0};
  int last_run[3]  = '{default: 0};
  int idle_run[3]  = '{default: 0};
  int last_idle[3] = '{default: 0};
  int done_cnt[3]  = '{default: 0};
  logic cap[3][64];

  logic       tx_w[3], busy_w[3], done_w[3];
  logic [2:0] fc_w[3];

  uart_tx_param_if #(.DATA_W(8)) if0 ();
  uart_tx_param_if #(.DATA_W(8)) if1 ();
  uart_tx_param_if #(.DATA_W(5)) if2 ();

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .s(if0), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]), .fifo_count(fc_w[0]));
  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .s(if1), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]), .fifo_count(fc_w[1]));
  uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .s(if2), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]), .fifo_count(fc_w[2]));

  function automatic int dw_of(input int k);
    return (k == 2) ? 5 : 8;
  endfunction
  function automatic int pm_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 0);
  endfunction
  function automatic int sb_of(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s[u%0d] got=%0h want=%0h at %0t", nm, k, act, want, $time);
    end
  endtask

  // Frame as a list of serial bit values, each stretched to CPB clocks.
  task automatic push_frame(input int k, input logic [15:0] w_in);
    logic [15:0] w;
    logic        bits[$];
    logic        p;
    w = w_in & 16'((32'd1 << dw_of(k)) - 1);
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < dw_of(k); i++) begin
      bits.push_back(w[i]);
      p ^= w[i];
    end
    if (pm_of(k) == 1)      bits.push_back(p);
    else if (pm_of(k) == 2) bits.push_back(!p);
    for (int i = 0; i < sb_of(k); i++) bits.push_back(1'b1);
    for (int i = 0; i < bits.size(); i++)
      for (int j = 0; j < CPB; j++)
        exp_q[k].push_back('{tx: bits[i], busy: 1'b1,
                             done: (i == bits.size() - 1) && (j == CPB - 1)});
  endtask

  task automatic cyc(input int k, input logic t, input logic b, input logic d,
                     input logic r, input logic v, input logic [15:0] w, input logic [2:0] fc);
    exp_t       e;
    logic       er;
    logic [2:0] efc;
    bit         was_empty;
    was_empty = (exp_q[k].size() == 0);
    if (was_empty) e = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
    else           e = exp_q[k].pop_front();
    if (rst) e.done = 1'b0;
`ifdef UART_TX_FIFO_EN
    er  = !rst && (mfifo[k].size() < 4);
    efc = 3'(mfifo[k].size());
`else
    er  = was_empty && !rst;
    efc = '0;
`endif
    chk("tx", k, 32'(t), 32'(e.tx));
    chk("busy", k, 32'(b), 32'(e.busy));
    chk("tx_done", k, 32'(d), 32'(e.done));
    chk("s_ready", k, 32'(r), 32'(er));
    chk("fifo_count", k, 32'(fc), 32'(efc));
    if (d) done_cnt[k]++;
    if (b) begin
      if (run[k] < 64) cap[k][run[k]] = t;
      if (run[k] == 0) last_idle[k] = idle_run[k];
      run[k]++;
      idle_run[k] = 0;
    end else begin
      if (run[k] > 0) last_run[k] = run[k];
      run[k] = 0;
      idle_run[k]++;
    end
    if (rst) begin
      exp_q[k].delete();
      mfifo[k].delete();
    end else begin
`ifdef UART_TX_FIFO_EN
      if (exp_q[k].size() == 0 && mfifo[k].size() != 0) push_frame(k, mfifo[k].pop_front());
      if (v && er) mfifo[k].push_back(w);
`else
      if (v && er) push_frame(k, w);
`endif
    end
  endtask

  always @(negedge clk) begin
    cyc(0, tx_w[0], busy_w[0], done_w[0], if0.s_ready, if0.s_valid, 16'(if0.s_data), fc_w[0]);
    cyc(1, tx_w[1], busy_w[1], done_w[1], if1.s_ready, if1.s_valid, 16'(if1.s_data), fc_w[1]);
    cyc(2, tx_w[2], busy_w[2], done_w[2], if2.s_ready, if2.s_valid, 16'(if2.s_data), fc_w[2]);
  end

  task automatic drv(input int k, input logic v, input logic [15:0] w);
    case (k)
      0: begin if0.s_valid = v; if0.s_data = w[7:0]; end
      1: begin if1.s_valid = v; if1.s_data = w[7:0]; end
      default: begin if2.s_valid = v; if2.s_data = w[4:0]; end
    endcase
  endtask

  function automatic logic rdy(input int k);
    case (k)
      0: return if0.s_ready;
      1: return if1.s_ready;
      default: return if2.s_ready;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge, valid still high.
  task automatic send(input int k, input logic [15:0] w);
    bit ok;
    ok = 1'b0;
    drv(k, 1'b1, w);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (rdy(k)) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    chk("accept_timeout", k, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int k);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk); #1;
      if (!busy_w[k] && exp_q[k].size() == 0 && mfifo[k].size() == 0) begin ok = 1'b1; break; end
    end
    chk("idle_timeout", k, 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic rand_stream(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      send(k, 16'($urandom));
      drv(k, 1'b0, 16'h0);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         d0, hi;
    logic [10:0] slots;
    slots = 11'b10101001010;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) drv(k, 1'b0, 16'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    d0 = done_cnt[0];
    send(0, 16'hA5); drv(0, 1'b0, 16'h0); wait_idle(0);
    chk("a5_busy_len", 0, 32'(last_run[0]), 32'd44);
    chk("a5_done_pulses", 0, 32'(done_cnt[0] - d0), 32'd1);
    for (int i = 0; i < 11; i++) chk("a5_slot", 0, 32'(cap[0][4*i+2]), 32'(slots[i]));

    send(1, 16'h07); drv(1, 1'b0, 16'h0); wait_idle(1);
    chk("odd2_busy_len", 1, 32'(last_run[1]), 32'd48);
    chk("odd_parity_bit", 1, 32'(cap[1][38]), 32'd0);
    hi = 0;
    for (int i = 40; i < 48; i++) hi += int'(cap[1][i]);
    chk("stop_high_clks", 1, 32'(hi), 32'd8);

    send(2, 16'h1F); drv(2, 1'b0, 16'h0); wait_idle(2);
    chk("w5_busy_len", 2, 32'(last_run[2]), 32'd28);
    chk("w5_last_data", 2, 32'(cap[2][22]), 32'd1);
    chk("w5_stop", 2, 32'(cap[2][26]), 32'd1);

`ifdef UART_TX_FIFO_EN
    d0 = done_cnt[0];
    for (int i = 1; i <= 5; i++) send(0, 16'(8'h11 * i));
    drv(0, 1'b0, 16'h0); wait_idle(0);
    chk("fifo_done_pulses", 0, 32'(done_cnt[0] - d0), 32'd5);
    chk("fifo_gapless_len", 0, 32'(last_run[0]), 32'd220);
    chk("fifo_count_empty", 0, 32'(fc_w[0]), 32'd0);
`else
    for (int i = 0; i < 3; i++) send(0, 16'($urandom));
    drv(0, 1'b0, 16'h0); wait_idle(0);
    chk("held_idle_gap", 0, 32'(last_idle[0]), 32'd1);
`endif

    d0 = done_cnt[0];
    send(0, 16'($urandom)); drv(0, 1'b0, 16'h0);
    hi = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (run[0] >= 20) begin hi = 1; break; end
    end
    chk("reach_clk20", 0, 32'(hi), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    drv(0, 1'b1, 16'h5A);
    @(posedge clk); #1;
    rst = 1'b0;
    drv(0, 1'b0, 16'h0);
    chk("rst_tx_high", 0, 32'(tx_w[0]), 32'd1);
    chk("rst_busy_low", 0, 32'(busy_w[0]), 32'd0);
    @(negedge clk); #1;
    chk("rst_no_done", 0, 32'(done_cnt[0] - d0), 32'd0);
    @(posedge clk); #1;
    d0 = done_cnt[0];
    send(0, 16'h3C); drv(0, 1'b0, 16'h0); wait_idle(0);
    chk("post_rst_done", 0, 32'(done_cnt[0] - d0), 32'd1);
    chk("post_rst_len", 0, 32'(last_run[0]), 32'd44);

    fork
      rand_stream(0, 20);
      rand_stream(1, 20);
      rand_stream(2, 20);
    join
    for (int k = 0; k < 3; k++) wait_idle(k);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
